muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit that sits beside the `alu` in the execute stage of the single-cycle core. It takes the same `A`/`B` operands as the ALU and produces `mdRes`, which the writeback mux selects instead of `aluRes` for M-extension instructions. The unit is multi-cycle. The control unit stalls the PC while `busy` is high and retires the instruction on `done`.

---
 rtl/muldiv_unit_if.sv | 21 ++
 rtl/muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/result bundle between execute control and muldiv_unit
interface muldiv_unit_if;
    logic        start;
    logic        flush;
    logic [2:0]  mdOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] mdRes;

    modport master (
        output start, flush, mdOp, A, B,
        input  busy, done, mdRes
    );

    modport slave (
        input  start, flush, mdOp, A, B,
        output busy, done, mdRes
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide, fixed 32-iteration latency
module muldiv_unit (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave md
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    state_t      state;
    logic [4:0]  cnt;
    logic [2:0]  op;
    logic [31:0] ma;
    logic [31:0] mb;
    logic        neg_res;
    logic        neg_rem;
    logic        div0;
    logic        ovf;
    logic [63:0] acc;
    logic [31:0] res_q;
    logic        busy_q;
    logic        done_q;

    logic        a_signed;
    logic        b_signed;
    logic        sa;
    logic        sb;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (md.mdOp)
            OP_MULH:   begin a_signed = 1'b1; b_signed = 1'b1; end
            OP_MULHSU: begin a_signed = 1'b1; b_signed = 1'b0; end
            OP_DIV:    begin a_signed = 1'b1; b_signed = 1'b1; end
            OP_REM:    begin a_signed = 1'b1; b_signed = 1'b1; end
            default:   begin a_signed = 1'b0; b_signed = 1'b0; end
        endcase
    end

    assign sa    = a_signed & md.A[31];
    assign sb    = b_signed & md.B[31];
    assign a_mag = sa ? (32'd0 - md.A) : md.A;
    assign b_mag = sb ? (32'd0 - md.B) : md.B;

    // Multiply walks the multiplier MSB-first so the partial product only ever shifts left.
    logic [63:0] mul_step;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        q_bit;
    logic [63:0] div_step;
    logic [63:0] acc_nxt;

    assign mul_step  = {acc[62:0], 1'b0} + (mb[~cnt] ? {32'd0, ma} : 64'd0);
    assign div_shift = {acc[63:32], ma[~cnt]};
    assign div_diff  = div_shift - {1'b0, mb};
    assign q_bit     = ~div_diff[32];
    assign div_step  = {(q_bit ? div_diff[31:0] : div_shift[31:0]), acc[30:0], q_bit};
    assign acc_nxt   = op[2] ? div_step : mul_step;

    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem_val;
    logic [31:0] final_res;

    assign prod    = neg_res ? (64'd0 - acc_nxt) : acc_nxt;
    assign quo     = neg_res ? (32'd0 - acc_nxt[31:0]) : acc_nxt[31:0];
    assign rem_val = neg_rem ? (32'd0 - acc_nxt[63:32]) : acc_nxt[63:32];

    always_comb begin
        final_res = 32'd0;
        case (op)
            OP_MUL:                        final_res = prod[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod[63:32];
            OP_DIV, OP_DIVU: begin
                if (div0)      final_res = 32'hFFFF_FFFF;
                else if (ovf)  final_res = 32'h8000_0000;
                else           final_res = quo;
            end
            default: begin
                // With a zero divisor the remainder path already reproduces A.
                if (ovf)       final_res = 32'd0;
                else           final_res = rem_val;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            op      <= 3'd0;
            ma      <= 32'd0;
            mb      <= 32'd0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
            ovf     <= 1'b0;
            acc     <= 64'd0;
            res_q   <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (md.flush) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                BUSY: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        res_q  <= final_res;
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    if (md.start) begin
                        state   <= BUSY;
                        busy_q  <= 1'b1;
                        cnt     <= 5'd0;
                        acc     <= 64'd0;
                        op      <= md.mdOp;
                        ma      <= a_mag;
                        mb      <= b_mag;
                        neg_res <= sa ^ sb;
                        neg_rem <= sa;
                        div0    <= (md.B == 32'd0);
                        ovf     <= md.mdOp[2] & a_signed & b_signed &
                                   (md.A == 32'h8000_0000) & (md.B == 32'hFFFF_FFFF);
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign md.busy  = busy_q;
    assign md.done  = done_q;
    assign md.mdRes = res_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed vector bench for muldiv_unit
module tb_muldiv_unit;
    logic clk;
    logic rst_n;

    muldiv_unit_if md();

    muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (md)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[16];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches one op from IDLE/DONE and returns once done is seen or the budget expires.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcnt);
        md.mdOp  = op;
        md.A     = a;
        md.B     = b;
        md.start = 1'b1;
        tick();
        md.start = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (!md.done && lat < 40) begin
            if (md.busy) bcnt++;
            tick();
            lat++;
        end
    endtask

    int lat;
    int bcnt;
    int gap;
    int seen;

    initial begin
        vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3"};
        vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min_min"};
        vecs[2]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1"};
        vecs[3]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max"};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_m7_2"};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_m7_2"};
        vecs[6]  = '{3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, "divu_by0"};
        vecs[7]  = '{3'b111, 32'd5,          32'd0,         32'd5,         "remu_by0"};
        vecs[8]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"};
        vecs[9]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "rem_ovf"};
        vecs[10] = '{3'b101, 32'd100,        32'd7,         32'd14,        "divu_100_7"};
        vecs[11] = '{3'b111, 32'd100,        32'd7,         32'd2,         "remu_100_7"};
        vecs[12] = '{3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2"};
        vecs[13] = '{3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,         "rem_7_m2"};
        vecs[14] = '{3'b100, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, "div_m5_by0"};
        vecs[15] = '{3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, "rem_m5_by0"};

        rst_n    = 1'b0;
        md.start = 1'b0;
        md.flush = 1'b0;
        md.mdOp  = 3'd0;
        md.A     = 32'd0;
        md.B     = 32'd0;
        #12;
        check("reset_busy",  {31'd0, md.busy}, 32'd0);
        check("reset_done",  {31'd0, md.done}, 32'd0);
        check("reset_mdres", md.mdRes, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
            check({vecs[i].name, "_latency"}, 32'(lat), 32'd32);
            check({vecs[i].name, "_busycycles"}, 32'(bcnt), 32'd32);
            check({vecs[i].name, "_res"}, md.mdRes, vecs[i].exp);
            check({vecs[i].name, "_busy_at_done"}, {31'd0, md.busy}, 32'd0);
            tick();
            check({vecs[i].name, "_done_one_cycle"}, {31'd0, md.done}, 32'd0);
        end

        // start re-asserted mid-operation must not disturb the running MUL
        md.mdOp = 3'b000; md.A = 32'd7; md.B = 32'hFFFF_FFFD; md.start = 1'b1;
        tick();
        md.start = 1'b0;
        lat = 0;
        while (!md.done && lat < 40) begin
            if (lat == 9) begin
                md.mdOp = 3'b011; md.A = 32'hFFFF_FFFF; md.B = 32'hFFFF_FFFF; md.start = 1'b1;
            end
            if (lat == 10) md.start = 1'b0;
            tick();
            lat++;
        end
        md.start = 1'b0;
        check("ignored_start_latency", 32'(lat), 32'd32);
        check("ignored_start_res", md.mdRes, 32'hFFFF_FFEB);
        tick();

        // back-to-back: second start during the DONE cycle
        do_op(3'b100, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
        check("b2b_first_latency", 32'(lat), 32'd32);
        check("b2b_first_res", md.mdRes, 32'hFFFF_FFFD);
        md.mdOp = 3'b110; md.A = 32'hFFFF_FFF9; md.B = 32'd2; md.start = 1'b1;
        tick();
        md.start = 1'b0;
        gap = 1;
        check("b2b_busy_no_gap", {31'd0, md.busy}, 32'd1);
        check("b2b_done_dropped", {31'd0, md.done}, 32'd0);
        check("b2b_res_held", md.mdRes, 32'hFFFF_FFFD);
        while (!md.done && gap < 45) begin
            tick();
            gap++;
        end
        check("b2b_done_spacing", 32'(gap), 32'd33);
        check("b2b_second_res", md.mdRes, 32'hFFFF_FFFF);
        tick();

        // flush at E15
        md.mdOp = 3'b101; md.A = 32'd100; md.B = 32'd7; md.start = 1'b1;
        tick();
        md.start = 1'b0;
        for (int k = 0; k < 14; k++) tick();
        md.flush = 1'b1;
        tick();
        md.flush = 1'b0;
        check("flush_busy", {31'd0, md.busy}, 32'd0);
        check("flush_done", {31'd0, md.done}, 32'd0);
        check("flush_res_kept", md.mdRes, 32'hFFFF_FFFF);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (md.done || md.busy) seen++;
        end
        check("flush_no_done", 32'(seen), 32'd0);
        check("flush_res_after", md.mdRes, 32'hFFFF_FFFF);

        // asynchronous reset at E20
        md.mdOp = 3'b011; md.A = 32'hFFFF_FFFF; md.B = 32'hFFFF_FFFF; md.start = 1'b1;
        tick();
        md.start = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        check("prereset_busy", {31'd0, md.busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_busy", {31'd0, md.busy}, 32'd0);
        check("areset_done", {31'd0, md.done}, 32'd0);
        check("areset_mdres", md.mdRes, 32'd0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (md.done || md.busy) seen++;
        end
        check("postreset_idle", 32'(seen), 32'd0);
        check("postreset_res", md.mdRes, 32'd0);

        do_op(3'b011, 32'h1234_5678, 32'h0000_0010, lat, bcnt);
        check("fresh_start_latency", 32'(lat), 32'd32);
        check("fresh_start_res", md.mdRes, 32'h0000_0001);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
